// File: rtl/countdown_delay_meter.sv
// Measures clk cycles from a din rising edge to the following dout rising edge
// and hands the result out through a valid/ready register.
// Optional build macro COUNTDOWN_METER_SYNC_EN adds 2-flop input synchronizers.
module countdown_delay_meter #(
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             sin,
    input  logic             dout,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic             out_valid,
    output logic [CNT_W-1:0] meas_cycles,
    output logic             meas_sign,
    output logic             meas_timeout,
    output logic             overrun,
    output logic             busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic din_s;
    logic dout_s;
    logic in_primed;

`ifdef COUNTDOWN_METER_SYNC_EN
    logic [1:0] din_sync;
    logic [1:0] dout_sync;
    logic [1:0] primed;

    // in_primed marks the point where the synchronizer outputs reflect real input
    always_ff @(posedge clk) begin
        if (rst) begin
            din_sync  <= 2'b00;
            dout_sync <= 2'b00;
            primed    <= 2'b00;
        end else begin
            din_sync  <= {din_sync[0], din};
            dout_sync <= {dout_sync[0], dout};
            primed    <= {primed[0], 1'b1};
        end
    end

    assign din_s     = din_sync[1];
    assign dout_s    = dout_sync[1];
    assign in_primed = primed[1];
`else
    assign din_s     = din;
    assign dout_s    = dout;
    assign in_primed = 1'b1;
`endif

    logic din_prev;
    logic dout_prev;
    logic din_armed;
    logic din_rise;
    logic dout_rise;

    // din must be seen low after reset before a rise can start a measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            din_prev  <= 1'b0;
            dout_prev <= 1'b0;
            din_armed <= 1'b0;
        end else begin
            din_prev  <= din_s;
            dout_prev <= dout_s;
            if (in_primed && !din_s) begin
                din_armed <= 1'b1;
            end
        end
    end

    assign din_rise  = din_s & ~din_prev & din_armed;
    assign dout_rise = dout_s & ~dout_prev;

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] cnt_inc;
    logic             sign_reg;
    logic [CNT_W-1:0] stop_val;
    logic             stop_to;
    logic             start;
    logic             dout_stop;
    logic             to_stop;
    logic             emit;

    assign cnt_inc = counter + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (din_rise) state_next = COUNT;
            COUNT:   if (dout_stop || to_stop) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // dout wins over timeout when both land in the same COUNT cycle
    always_comb begin
        busy      = (state == COUNT);
        emit      = (state == EMIT);
        start     = (state == IDLE) && din_rise;
        dout_stop = (state == COUNT) && dout_rise;
        to_stop   = (state == COUNT) && !dout_rise && (cnt_inc == TIMEOUT_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            sign_reg <= 1'b0;
            stop_val <= '0;
            stop_to  <= 1'b0;
        end else begin
            if (start) begin
                counter  <= '0;
                sign_reg <= sin;
            end else if (busy && counter != TIMEOUT_V) begin
                counter <= cnt_inc;
            end
            if (dout_stop) begin
                stop_val <= cnt_inc;
                stop_to  <= 1'b0;
            end else if (to_stop) begin
                stop_val <= TIMEOUT_V;
                stop_to  <= 1'b1;
            end
        end
    end

    // A result is only accepted when the register is empty or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            meas_cycles  <= '0;
            meas_sign    <= 1'b0;
            meas_timeout <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (emit && (!out_valid || out_ready)) begin
                out_valid    <= 1'b1;
                meas_cycles  <= stop_val;
                meas_sign    <= sign_reg;
                meas_timeout <= stop_to;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (emit && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_countdown_delay_meter.sv
// Directed bench for countdown_delay_meter with a scoreboard of expected results
// that is drained by a monitor whenever a result is transferred.
`timescale 1ns/1ps
module tb_countdown_delay_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             sin;
    logic             dout;
    logic             out_ready;
    logic             clr_overrun;
    logic             out_valid;
    logic [CNT_W-1:0] meas_cycles;
    logic             meas_sign;
    logic             meas_timeout;
    logic             overrun;
    logic             busy;

    typedef struct {
        int   lo;
        int   hi;
        logic sign;
        logic to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   xfer_count = 0;

    countdown_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .sin          (sin),
        .dout         (dout),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .out_valid    (out_valid),
        .meas_cycles  (meas_cycles),
        .meas_sign    (meas_sign),
        .meas_timeout (meas_timeout),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drives one measurement; sin wanders once the start has surely been sampled
    task automatic apply_stimulus(input int n, input logic s, input logic fire_dout, input logic expect_result);
        exp_t e;
        din  = 1'b0;
        dout = 1'b0;
        tick(3);
        din = 1'b1;
        sin = s;
        if (expect_result) begin
            e.lo = n; e.hi = n; e.sign = s; e.to = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            if (i >= 4) sin = 1'($urandom);
        end
        if (fire_dout) dout = 1'b1;
        tick(5);
        dout = 1'b0;
        din  = 1'b0;
        tick(2);
    endtask

    // Scoreboard monitor: pops one expectation per transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            total++;
            assert (sb.size() != 0)
            else begin
                bad++;
                $error("[TB] FAIL unexpected_result: observed=%0d expected=none", meas_cycles);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                assert (!$isunknown({meas_cycles, meas_sign, meas_timeout, overrun, busy}))
                else begin
                    bad++;
                    $error("[TB] FAIL x_on_outputs: observed=%b expected=known", {meas_cycles, meas_sign, meas_timeout});
                end
                total++;
                assert (int'(meas_cycles) >= e.lo && int'(meas_cycles) <= e.hi)
                else begin
                    bad++;
                    $error("[TB] FAIL meas_cycles: observed=%0d expected=%0d..%0d", meas_cycles, e.lo, e.hi);
                end
                check_output("meas_sign", 32'(meas_sign), 32'(e.sign));
                check_output("meas_timeout", 32'(meas_timeout), 32'(e.to));
            end
            xfer_count++;
        end
    end

    initial begin
        int   x0;
        int   busy_cnt;
        exp_t e;

        rst = 1'b1; din = 1'b0; sin = 1'b0; dout = 1'b0;
        out_ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_meas_cycles", 32'(meas_cycles), 32'd0);
        check_output("rst_meas_sign", 32'(meas_sign), 32'd0);
        check_output("rst_meas_timeout", 32'(meas_timeout), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("[TB] basic 37-cycle measurement");
        out_ready = 1'b1;
        x0 = xfer_count;
        apply_stimulus(37, 1'b0, 1'b1, 1'b1);
        tick(5);
        check_output("one_valid_pulse", 32'(xfer_count), 32'(x0 + 1));
        check_output("valid_cleared", 32'(out_valid), 32'd0);

        $display("[TB] timeout with dout never rising");
        din = 1'b0; dout = 1'b0;
        tick(3);
        din = 1'b1; sin = 1'b0;
        e.lo = TIMEOUT; e.hi = TIMEOUT; e.sign = 1'b0; e.to = 1'b1;
        sb.push_back(e);
        busy_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check_output("busy_cycles", 32'(busy_cnt), 32'(TIMEOUT));
        din = 1'b0;
        tick(2);

        $display("[TB] sign captured at start");
        apply_stimulus(15, 1'b1, 1'b1, 1'b1);
        apply_stimulus(11, 1'b0, 1'b1, 1'b1);

        $display("[TB] backpressure and overrun");
        out_ready = 1'b0;
        apply_stimulus(12, 1'b1, 1'b1, 1'b1);
        apply_stimulus(20, 1'b0, 1'b1, 1'b0);
        check_output("bp_valid_held", 32'(out_valid), 32'd1);
        check_output("bp_cycles_held", 32'(meas_cycles), 32'd12);
        check_output("bp_sign_held", 32'(meas_sign), 32'd1);
        check_output("overrun_set", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check_output("overrun_cleared", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick(3);
        check_output("bp_drained", 32'(out_valid), 32'd0);

        $display("[TB] reset mid-measurement");
        din = 1'b0; dout = 1'b0;
        tick(3);
        din = 1'b1; sin = 1'b1;
        tick(6);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_no_result", 32'(out_valid), 32'd0);
        din = 1'b0;
        tick(3);
        apply_stimulus(9, 1'b1, 1'b1, 1'b1);

`ifdef COUNTDOWN_METER_SYNC_EN
        $display("[TB] asynchronous dout phase");
        for (int k = 0; k < 4; k++) begin
            din = 1'b0; dout = 1'b0;
            tick(4);
            din = 1'b1; sin = 1'b0;
            e.lo = 24; e.hi = 26; e.sign = 1'b0; e.to = 1'b0;
            sb.push_back(e);
            #(245.0 + $urandom_range(0, 9999) / 1000.0);
            dout = 1'b1;
            tick(6);
            din = 1'b0; dout = 1'b0;
            tick(3);
        end
`endif

        tick(10);
        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
